// File: rtl/vga_pkg.sv
// Shared constants, pixel/packet layouts and the clamp helper for the cursor overlay.
package vga_pkg;

    localparam int unsigned H_RES_DEF      = 1280;
    localparam int unsigned V_RES_DEF      = 1024;
    localparam int unsigned CUR_SIZE_DEF   = 16;
    localparam int unsigned FIFO_DEPTH_DEF = 4;

    localparam int unsigned COORD_W = 11;
    localparam int unsigned CMP_W   = COORD_W + 1;
    localparam int unsigned POS_W   = 13;
    localparam int unsigned DELTA_W = 9;
    localparam int unsigned BTN_W   = 3;
    localparam int unsigned CH_W    = 10;
    localparam int unsigned COLOR_W = 3 * CH_W;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } pixel_t;

    localparam pixel_t COLOR_BLACK = '{r: '0, g: '0, b: '0};
    localparam pixel_t COLOR_WHITE = '{r: '1, g: '1, b: '1};
    localparam pixel_t COLOR_RED   = '{r: '1, g: '0, b: '0};

    typedef struct packed {
        logic [BTN_W-1:0]   btn;
        logic [DELTA_W-1:0] dx;
        logic [DELTA_W-1:0] dy;
    } mouse_pkt_t;

    typedef enum logic {
        VBLANK = 1'b0,
        ACTIVE = 1'b1
    } vstate_t;

    // Saturate a signed position into [0, hi].
    function automatic logic [COORD_W-1:0] clamp_coord(input logic signed [POS_W-1:0] v,
                                                       input logic signed [POS_W-1:0] hi);
        logic [COORD_W-1:0] res;
        if (v[POS_W-1]) begin
            res = '0;
        end else if (v > hi) begin
            res = hi[COORD_W-1:0];
        end else begin
            res = v[COORD_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/vga_cursor_overlay_if.sv
// Mouse packet valid/ready channel into the cursor overlay.
interface vga_cursor_overlay_if;

    logic                        mouse_valid;
    logic [vga_pkg::DELTA_W-1:0] mouse_dx;
    logic [vga_pkg::DELTA_W-1:0] mouse_dy;
    logic [vga_pkg::BTN_W-1:0]   mouse_btn;
    logic                        mouse_ready;

    modport master (output mouse_valid, mouse_dx, mouse_dy, mouse_btn, input mouse_ready);
    modport slave  (input mouse_valid, mouse_dx, mouse_dy, mouse_btn, output mouse_ready);

endinterface

// File: rtl/mouse_pkt_fifo.sv
// Mouse packet buffer; a push takes priority, so draining only happens on cycles without one.
module mouse_pkt_fifo
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_valid,
    input  mouse_pkt_t push_data,
    output logic       push_ready,
    output logic       pop_c,
    output mouse_pkt_t head_c
);

    localparam int unsigned   AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CW       = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    mouse_pkt_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nx;
    logic          push_c;

    assign push_c = push_valid && push_ready;
    assign pop_c  = (count != '0) && !push_c;
    assign head_c = mem[rd_ptr];

    always_comb begin
        count_nx = count;
        if (push_c) begin
            count_nx = count + CW'(1);
        end else if (pop_c) begin
            count_nx = count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            push_ready <= 1'b1;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
            count      <= count_nx;
            push_ready <= (count_nx != FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/vga_cursor_overlay.sv
// Hardware mouse cursor: buffers mouse packets, tracks a clamped position and
// composites a square cursor, latched once per frame at the end of the active area.
module vga_cursor_overlay
    import vga_pkg::*;
#(
    parameter int unsigned H_RES      = H_RES_DEF,
    parameter int unsigned V_RES      = V_RES_DEF,
    parameter int unsigned CUR_SIZE   = CUR_SIZE_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                 pixel_clk,
    input  logic                 reset,
    input  logic [COORD_W-1:0]   X_pix,
    input  logic [COORD_W-1:0]   Y_pix,
    input  logic                 H_visible,
    input  logic                 V_visible,
    input  logic [COLOR_W-1:0]   bg_color,
    vga_cursor_overlay_if.slave  mouse,
    output logic [COLOR_W-1:0]   pixel_color,
    output logic [COORD_W-1:0]   cursor_x,
    output logic [COORD_W-1:0]   cursor_y
);

    localparam logic signed [POS_W-1:0] X_MAX    = POS_W'(H_RES - 1);
    localparam logic signed [POS_W-1:0] Y_MAX    = POS_W'(V_RES - 1);
    localparam logic [COORD_W-1:0]      X_CENTER = COORD_W'(H_RES / 2);
    localparam logic [COORD_W-1:0]      Y_CENTER = COORD_W'(V_RES / 2);
    localparam logic [CMP_W-1:0]        X_LIM    = CMP_W'(H_RES);
    localparam logic [CMP_W-1:0]        Y_LIM    = CMP_W'(V_RES);
    localparam logic [CMP_W-1:0]        CSZ      = CMP_W'(CUR_SIZE);
    localparam logic [CMP_W-1:0]        CSZ_M1   = CMP_W'(CUR_SIZE - 1);

    mouse_pkt_t             push_data;
    mouse_pkt_t             head_c;
    logic                   pop_c;
    logic                   fifo_ready;
    logic [BTN_W-1:0]       btn;
    logic [COORD_W-1:0]     sx;
    logic [COORD_W-1:0]     sy;
    logic [BTN_W-1:0]       sbtn;
    logic signed [POS_W-1:0] sum_x;
    logic signed [POS_W-1:0] sum_y;
    vstate_t                state;
    vstate_t                state_nx;
    logic                   latch_c;
    logic [CMP_W-1:0]       px, py, sxw, syw;
    logic                   in_cur_c;
    logic                   border_c;
    logic [COLOR_W-1:0]     pix_nx;
    logic                   unused_sbtn;

    assign push_data = '{btn: mouse.mouse_btn, dx: mouse.mouse_dx, dy: mouse.mouse_dy};
    assign mouse.mouse_ready = fifo_ready;

    mouse_pkt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (pixel_clk),
        .rst        (reset),
        .push_valid (mouse.mouse_valid),
        .push_data  (push_data),
        .push_ready (fifo_ready),
        .pop_c      (pop_c),
        .head_c     (head_c)
    );

    // Y movement is positive-up while rows grow downward.
    always_comb begin
        sum_x = signed'(POS_W'(cursor_x))
              + signed'({{(POS_W-DELTA_W){head_c.dx[DELTA_W-1]}}, head_c.dx});
        sum_y = signed'(POS_W'(cursor_y))
              - signed'({{(POS_W-DELTA_W){head_c.dy[DELTA_W-1]}}, head_c.dy});
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            state <= VBLANK;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        latch_c  = 1'b0;
        case (state)
            ACTIVE: if (!V_visible) begin
                state_nx = VBLANK;
                latch_c  = 1'b1;
            end
            VBLANK: if (V_visible) state_nx = ACTIVE;
            default: state_nx = VBLANK;
        endcase
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            cursor_x <= X_CENTER;
            cursor_y <= Y_CENTER;
            btn      <= '0;
            sx       <= X_CENTER;
            sy       <= Y_CENTER;
            sbtn     <= '0;
        end else begin
            if (pop_c) begin
                cursor_x <= clamp_coord(sum_x, X_MAX);
                cursor_y <= clamp_coord(sum_y, Y_MAX);
                btn      <= head_c.btn;
            end
            if (latch_c) begin
                sx   <= cursor_x;
                sy   <= cursor_y;
                sbtn <= btn;
            end
        end
    end

    assign unused_sbtn = ^sbtn[BTN_W-1:1];

    // Compositing uses the frame-stable shadow position only.
    always_comb begin
        px       = CMP_W'(X_pix);
        py       = CMP_W'(Y_pix);
        sxw      = CMP_W'(sx);
        syw      = CMP_W'(sy);
        in_cur_c = (px >= sxw) && (px < sxw + CSZ) && (py >= syw) && (py < syw + CSZ)
                && (px < X_LIM) && (py < Y_LIM);
        border_c = (px == sxw) || (px == sxw + CSZ_M1) || (py == syw) || (py == syw + CSZ_M1);
        pix_nx   = bg_color;
        if (!(H_visible && V_visible)) begin
            pix_nx = COLOR_BLACK;
        end else if (in_cur_c) begin
            pix_nx = border_c ? COLOR_BLACK : (sbtn[0] ? COLOR_RED : COLOR_WHITE);
        end
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            pixel_color <= '0;
        end else begin
            pixel_color <= pix_nx;
        end
    end

endmodule

// File: tb/tb_vga_cursor_overlay.sv
// Randomized scoreboard bench for vga_cursor_overlay against a frame-level reference model.
module tb_vga_cursor_overlay;

    localparam int H  = 1280;
    localparam int V  = 1024;
    localparam int CS = 16;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] X_pix, Y_pix;
    logic        H_visible, V_visible;
    logic [29:0] bg_color;
    logic [29:0] pixel_color;
    logic [10:0] cursor_x, cursor_y;

    vga_cursor_overlay_if mif();

    vga_cursor_overlay dut (
        .pixel_clk   (clk),
        .reset       (reset),
        .X_pix       (X_pix),
        .Y_pix       (Y_pix),
        .H_visible   (H_visible),
        .V_visible   (V_visible),
        .bg_color    (bg_color),
        .mouse       (mif),
        .pixel_color (pixel_color),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] pix;
        bit          cpos;
        int          ex;
        int          ey;
        bit          crdy;
        bit          erdy;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state: live position, drawn (shadow) position, buttons.
    int       m_x, m_y, m_sx, m_sy;
    logic [2:0] m_btn;
    bit       m_sred;
    bit       prev_vv;
    int       n_acc = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic logic [29:0] ref_pixel(input int x, input int y, input bit hv, input bit vv,
                                              input logic [29:0] bg);
        logic [29:0] red;
        red = {10'h3FF, 20'h0};
        if (!(hv && vv)) return 30'h0;
        if (x >= m_sx && x < m_sx + CS && y >= m_sy && y < m_sy + CS && x < H && y < V) begin
            if (x == m_sx || x == m_sx + CS - 1 || y == m_sy || y == m_sy + CS - 1) return 30'h0;
            return m_sred ? red : 30'h3FFFFFFF;
        end
        return bg;
    endfunction

    task automatic step(input int x, input int y, input bit hv, input bit vv, input logic [29:0] bg,
                        input bit mv, input int dx, input int dy, input logic [2:0] btn,
                        input bit cpos, input bit crdy, input bit erdy);
        exp_t e;
        X_pix = 11'(x); Y_pix = 11'(y); H_visible = hv; V_visible = vv; bg_color = bg;
        mif.mouse_valid = mv; mif.mouse_dx = 9'(dx); mif.mouse_dy = 9'(dy); mif.mouse_btn = btn;
        if (mv && mif.mouse_ready) begin
            n_acc++;
            m_x   = clampi(m_x + dx, 0, H - 1);
            m_y   = clampi(m_y - dy, 0, V - 1);
            m_btn = btn;
        end
        if (prev_vv && !vv) begin
            m_sx = m_x; m_sy = m_y; m_sred = m_btn[0];
        end
        prev_vv = vv;
        e.pix  = ref_pixel(x, y, hv, vv, bg);
        e.cpos = cpos; e.ex = m_x; e.ey = m_y;
        e.crdy = crdy; e.erdy = erdy;
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic visible(input int n, input int pct);
        for (int i = 0; i < n; i++) begin
            int x, y;
            bit mv;
            if ($urandom_range(0, 3) == 0) begin
                x = int'($urandom_range(0, 2047)); y = int'($urandom_range(0, 2047));
            end else begin
                x = m_sx - 2 + int'($urandom_range(0, 20)); y = m_sy - 2 + int'($urandom_range(0, 20));
            end
            x  = clampi(x, 0, 2047);
            y  = clampi(y, 0, 2047);
            mv = int'($urandom_range(0, 99)) < pct;
            step(x, y, $urandom_range(0, 7) != 0, 1'b1, 30'($urandom), mv,
                 int'($urandom_range(0, 510)) - 255, int'($urandom_range(0, 510)) - 255,
                 3'($urandom), 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic settle();
        for (int i = 0; i < 8; i++)
            step(m_sx + int'($urandom_range(0, 15)), m_sy + int'($urandom_range(0, 15)), 1'b1, 1'b1,
                 30'($urandom), 1'b0, 0, 0, 3'b0, i == 7, 1'b0, 1'b0);
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++)
            step(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)), 1'($urandom), 1'b0,
                 30'($urandom), 1'b0, 0, 0, 3'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic probes();
        int ox[8] = '{0, 1, 15, 16, 8, -1, 7, 15};
        int oy[8] = '{0, 1, 8, 8, 15, 5, 7, 15};
        for (int i = 0; i < 8; i++)
            step(clampi(m_sx + ox[i], 0, 2047), clampi(m_sy + oy[i], 0, 2047), 1'b1, 1'b1,
                 30'($urandom), 1'b0, 0, 0, 3'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic move(input int dx, input int dy, input logic [2:0] btn);
        step(m_sx, m_sy, 1'b1, 1'b1, 30'($urandom), 1'b1, dx, dy, btn, 1'b0, 1'b0, 1'b0);
        step(m_sx + 3, m_sy + 3, 1'b1, 1'b1, 30'($urandom), 1'b0, 0, 0, 3'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        V_visible = 1'b0; H_visible = 1'b0; mif.mouse_valid = 1'b0;
        m_x = H / 2; m_y = V / 2; m_sx = H / 2; m_sy = V / 2; m_btn = 3'b0; m_sred = 1'b0;
        prev_vv = 1'b0;
        #1;
        cmp("rst_ready", 32'(mif.mouse_ready), 32'd1);
        cmp("rst_cursor_x", 32'(cursor_x), 32'(H / 2));
        cmp("rst_cursor_y", 32'(cursor_y), 32'(V / 2));
        cmp("rst_pixel", 32'(pixel_color), 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Monitor: pixel_color is valid every cycle, one cycle after its inputs.
    initial begin
        forever begin
            int   n_due;
            exp_t e;
            @(posedge clk);
            n_due = exp_q.size();
            @(negedge clk);
            if (n_due > 0) begin
                e = exp_q.pop_front();
                cmp("pixel_color", 32'(pixel_color), 32'(e.pix));
                if (e.cpos) begin
                    cmp("cursor_x", 32'(cursor_x), 32'(e.ex));
                    cmp("cursor_y", 32'(cursor_y), 32'(e.ey));
                end
                if (e.crdy) cmp("mouse_ready", 32'(mif.mouse_ready), 32'(e.erdy));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        int rdy_pat[6] = '{1, 1, 1, 0, 1, 0};
        X_pix = '0; Y_pix = '0; H_visible = 1'b0; V_visible = 1'b0; bg_color = '0;
        mif.mouse_valid = 1'b0; mif.mouse_dx = '0; mif.mouse_dy = '0; mif.mouse_btn = '0;

        do_reset();
        step(0, 0, 1'b1, 1'b0, 30'($urandom), 1'b0, 0, 0, 3'b0, 1'b1, 1'b1, 1'b1);

        // Idle frame: centred white cursor, black blanking.
        visible(30, 0); probes(); blank(4);

        // +100/-50 move applies live quickly but is drawn only after the next latch.
        visible(10, 0);
        step(m_sx, m_sy, 1'b1, 1'b1, 30'($urandom), 1'b1, 100, 50, 3'b0, 1'b0, 1'b0, 1'b0);
        step(m_sx + 1, m_sy + 1, 1'b1, 1'b1, 30'($urandom), 1'b0, 0, 0, 3'b0, 1'b0, 1'b0, 1'b0);
        step(m_sx + 2, m_sy + 2, 1'b1, 1'b1, 30'($urandom), 1'b0, 0, 0, 3'b0, 1'b1, 1'b0, 1'b0);
        cmp("model_x_740", 32'(m_x), 32'd740);
        probes(); visible(10, 0); blank(4);
        probes(); visible(20, 0);

        // Left button turns the interior red in the next frame.
        move(0, 0, 3'b001); settle(); blank(4); probes(); visible(10, 0);

        // Saturation at both horizontal edges and the bottom edge, with clipping.
        for (int i = 0; i < 6; i++) move(-255, 0, 3'b000);
        settle(); blank(4); probes(); visible(10, 0);
        for (int i = 0; i < 8; i++) move(255, 0, 3'b000);
        for (int i = 0; i < 3; i++) move(0, -255, 3'b000);
        settle(); blank(4); probes();
        for (int i = 0; i < 12; i++)
            step(1276 + i, 1020 + (i % 8), 1'b1, 1'b1, 30'($urandom), 1'b0, 0, 0, 3'b0,
                 1'b0, 1'b0, 1'b0);
        blank(4);

        // Held valid: four back-to-back pushes fill the buffer, then it alternates.
        visible(4, 0); settle();
        acc0 = n_acc;
        for (int i = 0; i < 6; i++)
            step(m_sx, m_sy, 1'b1, 1'b1, 30'($urandom), 1'b1, int'($urandom_range(0, 40)) - 20,
                 int'($urandom_range(0, 40)) - 20, 3'b000, 1'b0, 1'b1, 1'(rdy_pat[i]));
        mif.mouse_valid = 1'b0;
        cmp("accepted_count", 32'(n_acc - acc0), 32'd5);
        settle(); blank(4); probes(); visible(5, 0);

        for (int r = 0; r < 6; r++) begin
            visible(30, 33); settle(); blank(4); probes(); visible(10, 0);
        end

        // Reset with packets still queued.
        settle();
        for (int i = 0; i < 3; i++)
            step(100, 100, 1'b0, 1'b1, 30'($urandom), 1'b1, 10 + i, 5, 3'b001, 1'b0, 1'b1, 1'b1);
        do_reset();
        blank(2); settle(); blank(4); probes(); visible(10, 0); blank(2);

        repeat (2) @(negedge clk);
        #1;
        cmp("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
